// File: rtl/ram_2p_asym_ctrl.sv
// rtl/ram_2p_asym_ctrl.sv - asymmetric-width dual-port RAM controller over N external narrow banks
module ram_2p_asym_ctrl #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 10,
  parameter int N        = (W_DATA_W > R_DATA_W) ? (W_DATA_W / R_DATA_W) : (R_DATA_W / W_DATA_W),
  localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W,
  localparam int LOG2N     = (N > 1) ? $clog2(N) : 0,
  localparam int MINADDR_W = ADDR_W - LOG2N,
  localparam int W_ADDR_W  = (W_DATA_W == MINDATA_W) ? ADDR_W : MINADDR_W,
  localparam int R_ADDR_W  = (R_DATA_W == MINDATA_W) ? ADDR_W : MINADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [W_ADDR_W-1:0]      w_addr,
  input  logic [W_DATA_W-1:0]      w_data,
  input  logic                     r_en,
  input  logic [R_ADDR_W-1:0]      r_addr,
  output logic [R_DATA_W-1:0]      r_data,
  output logic [N-1:0]             ext_mem_w_en,
  output logic [N*MINADDR_W-1:0]   ext_mem_w_addr,
  output logic [N*MINDATA_W-1:0]   ext_mem_w_data,
  output logic                     ext_mem_r_en,
  output logic [N*MINADDR_W-1:0]   ext_mem_r_addr,
  input  logic [N*MINDATA_W-1:0]   ext_mem_r_data
);

  // Parameter sanity: the bank count must match the width ratio and fit the address
  if ((N < 1) || ((N & (N - 1)) != 0)) begin : g_chk_pow2
    $error("ram_2p_asym_ctrl: N=%0d is not a power of two", N);
  end
  if (N * MINDATA_W != MAXDATA_W) begin : g_chk_ratio
    $error("ram_2p_asym_ctrl: N=%0d does not equal MAXDATA_W/MINDATA_W", N);
  end
  if (ADDR_W < LOG2N) begin : g_chk_addr
    $error("ram_2p_asym_ctrl: ADDR_W=%0d smaller than log2(N)=%0d", ADDR_W, LOG2N);
  end

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  if (W_DATA_W >= R_DATA_W) begin : g_wr_wide
    // A wide word spans every bank at the same row; bank p takes lane p (N=1 is pass-through)
    always_comb begin
      ext_mem_w_en   = rst ? '0 : {N{w_en}};
      ext_mem_w_addr = '0;
      ext_mem_w_data = '0;
      for (int p = 0; p < N; p++) begin
        ext_mem_w_addr[p*MINADDR_W +: MINADDR_W] = w_addr;
        ext_mem_w_data[p*MINDATA_W +: MINDATA_W] = w_data[p*MINDATA_W +: MINDATA_W];
      end
    end
  end else begin : g_wr_narrow
    logic [LOG2N-1:0] wsel;
    assign wsel = w_addr[LOG2N-1:0];

    // A narrow unit goes to bank (addr mod N) at row (addr >> log2N); data is replicated
    always_comb begin
      ext_mem_w_en   = '0;
      ext_mem_w_addr = '0;
      ext_mem_w_data = '0;
      for (int p = 0; p < N; p++) begin
        ext_mem_w_en[p] = w_en & ~rst & (wsel == LOG2N'(p));
        ext_mem_w_addr[p*MINADDR_W +: MINADDR_W] = w_addr[ADDR_W-1:LOG2N];
        ext_mem_w_data[p*MINDATA_W +: MINDATA_W] = w_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  if (R_DATA_W >= W_DATA_W) begin : g_rd_wide
    // Every bank reads the same row; concatenated bank outputs form the wide word
    always_comb begin
      ext_mem_r_en   = r_en & ~rst;
      ext_mem_r_addr = '0;
      for (int p = 0; p < N; p++) begin
        ext_mem_r_addr[p*MINADDR_W +: MINADDR_W] = r_addr;
      end
      r_data = ext_mem_r_data;
    end
  end else begin : g_rd_narrow
    logic [LOG2N-1:0] rsel_d;
    logic [LOG2N-1:0] rsel_q;

    // Next lane select: capture the low address bits of an accepted read, else hold
    always_comb begin
      rsel_d = rsel_q;
      if (r_en) begin
        rsel_d = r_addr[LOG2N-1:0];
      end
    end

    // Lane select register; reset also drops the read that arrives with it
    always_ff @(posedge clk) begin
      if (rst) begin
        rsel_q <= '0;
      end else begin
        rsel_q <= rsel_d;
      end
    end

    // Drive bank row address and pick the lane registered alongside the bank data
    always_comb begin
      ext_mem_r_en   = r_en & ~rst;
      ext_mem_r_addr = '0;
      for (int p = 0; p < N; p++) begin
        ext_mem_r_addr[p*MINADDR_W +: MINADDR_W] = r_addr[ADDR_W-1:LOG2N];
      end
      r_data = ext_mem_r_data[MINDATA_W-1:0];
      for (int p = 1; p < N; p++) begin
        if (rsel_q == LOG2N'(p)) begin
          r_data = ext_mem_r_data[p*MINDATA_W +: MINDATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_2p_asym_ctrl.sv
// tb/tb_ram_2p_asym_ctrl.sv - directed checks of ram_2p_asym_ctrl in 32:8, 8:32 and 16:16 configs
module tb_ram_2p_asym_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Config A: W=32, R=8, N=4, MINADDR_W=8
  logic        a_w_en;
  logic [7:0]  a_w_addr;
  logic [31:0] a_w_data;
  logic        a_r_en;
  logic [9:0]  a_r_addr;
  logic [7:0]  a_r_data;
  logic [3:0]  a_mw_en;
  logic [31:0] a_mw_addr, a_mw_data, a_mr_addr, a_mr_data;
  logic        a_mr_en;
  logic [7:0]  a_mem [4][256];

  // Config B: W=8, R=32, N=4, MINADDR_W=8
  logic        b_w_en;
  logic [9:0]  b_w_addr;
  logic [7:0]  b_w_data;
  logic        b_r_en;
  logic [7:0]  b_r_addr;
  logic [31:0] b_r_data;
  logic [3:0]  b_mw_en;
  logic [31:0] b_mw_addr, b_mw_data, b_mr_addr, b_mr_data;
  logic        b_mr_en;
  logic [7:0]  b_mem [4][256];

  // Config C: W=R=16, N=1
  logic        c_w_en;
  logic [9:0]  c_w_addr;
  logic [15:0] c_w_data;
  logic        c_r_en;
  logic [9:0]  c_r_addr;
  logic [15:0] c_r_data;
  logic [0:0]  c_mw_en;
  logic [9:0]  c_mw_addr, c_mr_addr;
  logic [15:0] c_mw_data, c_mr_data;
  logic        c_mr_en;
  logic [15:0] c_mem [1024];

  ram_2p_asym_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(10)) u_a (
    .clk(clk), .rst(rst),
    .w_en(a_w_en), .w_addr(a_w_addr), .w_data(a_w_data),
    .r_en(a_r_en), .r_addr(a_r_addr), .r_data(a_r_data),
    .ext_mem_w_en(a_mw_en), .ext_mem_w_addr(a_mw_addr), .ext_mem_w_data(a_mw_data),
    .ext_mem_r_en(a_mr_en), .ext_mem_r_addr(a_mr_addr), .ext_mem_r_data(a_mr_data)
  );

  ram_2p_asym_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(10)) u_b (
    .clk(clk), .rst(rst),
    .w_en(b_w_en), .w_addr(b_w_addr), .w_data(b_w_data),
    .r_en(b_r_en), .r_addr(b_r_addr), .r_data(b_r_data),
    .ext_mem_w_en(b_mw_en), .ext_mem_w_addr(b_mw_addr), .ext_mem_w_data(b_mw_data),
    .ext_mem_r_en(b_mr_en), .ext_mem_r_addr(b_mr_addr), .ext_mem_r_data(b_mr_data)
  );

  ram_2p_asym_ctrl #(.W_DATA_W(16), .R_DATA_W(16), .ADDR_W(10)) u_c (
    .clk(clk), .rst(rst),
    .w_en(c_w_en), .w_addr(c_w_addr), .w_data(c_w_data),
    .r_en(c_r_en), .r_addr(c_r_addr), .r_data(c_r_data),
    .ext_mem_w_en(c_mw_en), .ext_mem_w_addr(c_mw_addr), .ext_mem_w_data(c_mw_data),
    .ext_mem_r_en(c_mr_en), .ext_mem_r_addr(c_mr_addr), .ext_mem_r_data(c_mr_data)
  );

  // Bank models: registered read, read-before-write on the same row
  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (a_mw_en[p]) a_mem[p][a_mw_addr[p*8 +: 8]] <= a_mw_data[p*8 +: 8];
      if (a_mr_en)    a_mr_data[p*8 +: 8] <= a_mem[p][a_mr_addr[p*8 +: 8]];
      if (b_mw_en[p]) b_mem[p][b_mw_addr[p*8 +: 8]] <= b_mw_data[p*8 +: 8];
      if (b_mr_en)    b_mr_data[p*8 +: 8] <= b_mem[p][b_mr_addr[p*8 +: 8]];
    end
    if (c_mw_en[0]) c_mem[c_mw_addr] <= c_mw_data;
    if (c_mr_en)    c_mr_data <= c_mem[c_mr_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] rd_addr [5] = '{10'd0, 10'd1, 10'd4, 10'd1021, 10'd1023};
  logic [7:0] rd_exp  [5] = '{8'h0A, 8'h00, 8'h0B, 8'h01, 8'h00};
  logic [9:0] hold_addr [3] = '{10'd0, 10'd1, 10'd3};
  logic [3:0] exp_en;

  initial begin
    rst = 1'b1;
    a_w_en = 1'b1; a_w_addr = '0; a_w_data = 32'hFFFF_FFFF; a_r_en = 1'b1; a_r_addr = '0;
    b_w_en = 1'b1; b_w_addr = '0; b_w_data = '0; b_r_en = 1'b1; b_r_addr = '0;
    c_w_en = 1'b1; c_w_addr = '0; c_w_data = '0; c_r_en = 1'b1; c_r_addr = '0;
    tick();
    check("rst_a_wen", a_mw_en, 0);
    check("rst_a_ren", a_mr_en, 0);
    check("rst_b_wen", b_mw_en, 0);
    check("rst_b_ren", b_mr_en, 0);
    check("rst_c_wen", c_mw_en, 0);
    check("rst_c_ren", c_mr_en, 0);
    a_w_en = 1'b0; a_r_en = 1'b0; b_w_en = 1'b0; b_r_en = 1'b0; c_w_en = 1'b0; c_r_en = 1'b0;
    tick();
    rst = 1'b0;

    // Config A: fill every wide word with i+10
    for (int i = 0; i < 256; i++) begin
      a_w_en = 1'b1; a_w_addr = i[7:0]; a_w_data = i + 10;
      #1;
      check("a_fill_wen", a_mw_en, 4'b1111);
      check("a_fill_addr", a_mw_addr, {4{i[7:0]}});
      check("a_fill_data", a_mw_data, i + 10);
      tick();
    end
    a_w_en = 1'b0;

    // Back-to-back narrow reads, one per cycle
    for (int k = 0; k < 5; k++) begin
      a_r_en = 1'b1; a_r_addr = rd_addr[k];
      #1;
      check("a_rd_bank_addr", a_mr_addr, {4{rd_addr[k][9:2]}});
      check("a_rd_ren", a_mr_en, 1);
      tick();
      check("a_rd_data", a_r_data, rd_exp[k]);
    end
    a_r_en = 1'b0;

    // Overwrite word 0 then read byte 2 and hold it with r_en low
    a_w_en = 1'b1; a_w_addr = 8'd0; a_w_data = 32'hDDCC_BBAA;
    tick();
    a_w_en = 1'b0; a_r_en = 1'b1; a_r_addr = 10'd2;
    tick();
    check("a_byte2", a_r_data, 8'hCC);
    a_r_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_r_addr = hold_addr[k];
      #1;
      check("a_hold_ren", a_mr_en, 0);
      tick();
      check("a_hold_data", a_r_data, 8'hCC);
    end

    // Same-row read and write: read returns old contents
    a_w_en = 1'b1; a_w_addr = 8'd0; a_w_data = 32'h1122_3344;
    a_r_en = 1'b1; a_r_addr = 10'd0;
    tick();
    check("a_rbw_old", a_r_data, 8'hAA);
    a_w_en = 1'b0;
    tick();
    check("a_rbw_new0", a_r_data, 8'h44);
    a_r_addr = 10'd3;
    tick();
    check("a_rbw_new3", a_r_data, 8'h11);

    // Reset with write and read requests pending
    rst = 1'b1;
    a_w_en = 1'b1; a_w_addr = 8'd0; a_w_data = 32'hFFFF_FFFF;
    a_r_en = 1'b1; a_r_addr = 10'h3FD;
    #1;
    check("a_rst_wen", a_mw_en, 0);
    check("a_rst_ren", a_mr_en, 0);
    check("a_rst_waddr", a_mw_addr, 32'h0);
    check("a_rst_wdata", a_mw_data, 32'hFFFF_FFFF);
    check("a_rst_raddr", a_mr_addr, 32'hFFFF_FFFF);
    tick();
    rst = 1'b0; a_w_en = 1'b0; a_r_en = 1'b0;
    #1;
    check("a_rst_rsel0", a_r_data, 8'h44);
    a_r_en = 1'b1; a_r_addr = 10'd0;
    tick();
    check("a_post_rst_b0", a_r_data, 8'h44);
    a_r_addr = 10'd3;
    tick();
    check("a_post_rst_b3", a_r_data, 8'h11);
    a_r_en = 1'b0;

    // Config B: narrow write lands in one bank with data replicated
    b_w_en = 1'b1; b_w_addr = 10'd5; b_w_data = 8'h0F;
    #1;
    check("b_w5_wen", b_mw_en, 4'b0010);
    check("b_w5_addr", b_mw_addr, 32'h0101_0101);
    check("b_w5_data", b_mw_data, 32'h0F0F_0F0F);
    tick();
    for (int k = 0; k < 4; k++) begin
      b_w_addr = 10'd4 + 10'(k); b_w_data = 8'(k + 1);
      exp_en = 4'b0001 << k;
      #1;
      check("b_lo_wen", b_mw_en, exp_en);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      b_w_addr = 10'd1020 + 10'(k); b_w_data = 8'hA0 + 8'(k);
      #1;
      check("b_top_addr", b_mw_addr, 32'hFFFF_FFFF);
      tick();
    end
    b_w_en = 1'b0;
    b_r_en = 1'b1; b_r_addr = 8'd1;
    #1;
    check("b_rd_addr", b_mr_addr, 32'h0101_0101);
    tick();
    check("b_rd1", b_r_data, 32'h0403_0201);
    b_r_addr = 8'd255;
    tick();
    check("b_rd255", b_r_data, 32'hA3A2_A1A0);
    b_r_en = 1'b0; b_r_addr = 8'd1;
    tick();
    check("b_hold", b_r_data, 32'hA3A2_A1A0);

    // Config C: equal widths pass straight through
    c_w_en = 1'b1; c_w_addr = 10'h3FF; c_w_data = 16'hBEEF;
    #1;
    check("c_wen", c_mw_en, 1);
    check("c_waddr", c_mw_addr, 10'h3FF);
    check("c_wdata", c_mw_data, 16'hBEEF);
    tick();
    c_w_en = 1'b0; c_r_en = 1'b1; c_r_addr = 10'h3FF;
    #1;
    check("c_raddr", c_mr_addr, 10'h3FF);
    check("c_ren", c_mr_en, 1);
    tick();
    check("c_rdata", c_r_data, 16'hBEEF);
    c_r_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_2p_asym_ctrl.md
Name: ram_2p_asym_ctrl

Overview:
- Dual-port RAM controller: one write port, one read port, independent data widths (W_DATA_W, R_DATA_W), single clock.
- Built on N = MAXDATA_W/MINDATA_W external banks. Each bank is a simple 2-port RAM, MINDATA_W wide, MINADDR_W deep, 1-cycle registered read.
- Maps the wide or narrow port accesses onto the bank array in little-endian order and returns narrow or wide read data.
- The bank RAMs live outside the block and connect through the ext_mem_* ports.

Parameters:
- W_DATA_W, 32: write data width.
- R_DATA_W, 8: read data width.
- ADDR_W, 10: address width of the narrower port (MAXADDR_W).
- N, MAX(W_DATA_W,R_DATA_W)/MIN(W_DATA_W,R_DATA_W): bank count. Ratio must be a power of two ≥ 1.
- Derived MAXDATA_W = max(W_DATA_W, R_DATA_W).
- Derived MINDATA_W = min(W_DATA_W, R_DATA_W).
- Derived MINADDR_W = ADDR_W − log2(N).
- Derived W_ADDR_W = ADDR_W if W_DATA_W == MINDATA_W, else MINADDR_W.
- Derived R_ADDR_W = ADDR_W if R_DATA_W == MINDATA_W, else MINADDR_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write strobe.
- w_addr  in  W_ADDR_W  write address, in W_DATA_W units.
- w_data  in  W_DATA_W  write data.
- r_en  in  1  read strobe.
- r_addr  in  R_ADDR_W  read address, in R_DATA_W units.
- r_data  out  R_DATA_W  read data, valid the cycle after r_en.
- ext_mem_w_en  out  N  per-bank write enable.
- ext_mem_w_addr  out  N*MINADDR_W  bank p address in slice [p*MINADDR_W +: MINADDR_W].
- ext_mem_w_data  out  N*MINDATA_W  bank p data in slice [p*MINDATA_W +: MINDATA_W].
- ext_mem_r_en  out  1  common read enable to all banks.
- ext_mem_r_addr  out  N*MINADDR_W  per-bank read address.
- ext_mem_r_data  in  N*MINDATA_W  per-bank read data, registered by the bank 1 cycle after ext_mem_r_en.

Behaviour:
- Byte order: memory is little-endian. Narrow unit k lives in bank k mod N at bank address k >> log2(N).
- Wide word j occupies banks 0..N−1 at bank address j; bank p holds bits [p*MINDATA_W +: MINDATA_W].
- Equal widths (N=1): all ext signals pass straight through; r_data = ext_mem_r_data.
- W > R, write side (wide): ext_mem_w_en = {N{w_en}}; every bank address = w_addr; bank p data = w_data[p*MINDATA_W +: MINDATA_W].
- W > R, read side (narrow):
  - Every bank read address = r_addr[ADDR_W-1:log2N]; ext_mem_r_en = r_en.
  - Select register rsel (log2N bits) loads r_addr[log2N-1:0] on a clock edge with r_en=1; otherwise it holds.
  - r_data = ext_mem_r_data[rsel*MINDATA_W +: MINDATA_W], combinational from the bank outputs.
- W < R, write side (narrow):
  - wsel = w_addr[log2N-1:0].
  - ext_mem_w_en bit p = w_en & (p == wsel); exactly one bank is written.
  - All bank write addresses = w_addr[ADDR_W-1:log2N].
  - w_data is replicated to every bank data slice.
- W < R, read side (wide): all bank read addresses = r_addr; ext_mem_r_en = r_en; r_data = ext_mem_r_data, with bank p in bits [p*MINDATA_W +: MINDATA_W].
- Read latency: exactly 1 clk. r_data after edge t reflects r_addr sampled at edge t with r_en=1.
- With r_en=0, r_data holds its last value: banks hold, and rsel holds.
- Reset (sync, high):
  - rsel clears to 0.
  - While rst=1, ext_mem_w_en = 0 and ext_mem_r_en = 0, so no access reaches the banks.
  - Addresses and data still drive their mapped values.
  - Memory contents are not cleared.
  - A read issued in the same cycle as rst is discarded.
  - Reset mid-sequence only affects cycles where rst=1; operation resumes on the next edge.
- Simultaneous read and write to the same location: the read returns the old bank contents (read-before-write, as the banks implement it). The controller adds no bypass.
- Address wrap: no range checking; addresses use all bits, so top-of-range accesses wrap naturally within the bank depth.
- Elaboration checks:
  - Error if N is not a power of two.
  - Error if N ≠ MAXDATA_W/MINDATA_W.
  - Error if ADDR_W < log2(N).

Test Plan:
- Setup: W=32, R=8, ADDR_W=10, N=4, MINADDR_W=8. Write w_addr i = i+10 for i=0..255 → each cycle ext_mem_w_en=4'b1111 and all bank addresses = i.
- Same memory, read r_addr=0,1,4,1023 one per cycle → r_data = 0x0A, 0x00, 0x0B, 0x00 (byte 3 of 0x109), each one cycle after issue.
- Setup: W=8, R=32, ADDR_W=10. Write w_addr=5 data 0x0F → ext_mem_w_en=4'b0010, bank addr=1, all data slices 0x0F. Write bytes 4..7 = 1,2,3,4, then read r_addr=1 → r_data=0x04030201.
- Setup: W=R=16, N=1. Write addr 0x3FF=0xBEEF, read 0x3FF → 0xBEEF one cycle later; ext ports equal the user ports.
- Narrow-read config: issue a read of r_addr=2, then hold r_en=0 with r_addr changing → r_data stays at the byte-2 value.
- Reset: assert rst with w_en=1 → ext_mem_w_en=0 and the location keeps its old data. After reset, read r_addr=0 → correct byte, confirming rsel=0 at reset.
